// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM request arbiter.
package sram_arb_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int NUM_WMASKS_DEF = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic idx;
  } tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic r_last;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      r_last <= grant[1];
    end
  end
endmodule

// File: rtl/sram_rw_arbiter.sv
// Two-requester front end for a 1RW SRAM macro: zero-fill after reset, round-robin
// arbitration, registered macro command and tagged read-data return.
//
//   state    | meaning
//   ST_CLEAR | writing zeros to every word, requests held off
//   ST_RUN   | arbitrating and issuing one request per cycle
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int NUM_WMASKS     = NUM_WMASKS_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    clear_busy,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  tag_t                  r_tag1;
  tag_t                  r_tag2;
  logic [1:0]            w_grant;
  logic                  w_sel;
  logic                  w_hs;
  logic                  w_we;
  logic [NUM_WMASKS-1:0] w_wmask;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  rr_arb2 u_arb (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .valid   (req_valid),
    .advance (w_hs),
    .grant   (w_grant)
  );

  assign req_ready = (r_state == ST_RUN) ? w_grant : 2'b00;
  assign w_sel     = w_grant[1];
  assign w_hs      = |(req_valid & req_ready);

  always_comb begin
    if (w_sel) begin
      w_we    = req_we[1];
      w_wmask = req_wmask[2*NUM_WMASKS-1:NUM_WMASKS];
      w_addr  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      w_wdata = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      w_we    = req_we[0];
      w_wmask = req_wmask[NUM_WMASKS-1:0];
      w_addr  = req_addr[ADDR_WIDTH-1:0];
      w_wdata = req_wdata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clr_addr  <= '0;
      clear_busy  <= (CLEAR_ON_RESET != 0);
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      rsp_valid   <= 2'b00;
      rsp_rdata   <= '0;
    end else begin
      // Macro output is only valid at the edge two cycles after the handshake.
      r_tag2    <= r_tag1;
      rsp_valid <= 2'b00;
      if (r_tag2.valid) begin
        rsp_rdata            <= sram_dout0;
        rsp_valid[r_tag2.idx] <= 1'b1;
      end

      if (r_state == ST_CLEAR) begin
        sram_csb0   <= 1'b0;
        sram_web0   <= 1'b0;
        sram_wmask0 <= '1;
        sram_addr0  <= r_clr_addr;
        sram_din0   <= '0;
        r_tag1      <= '0;
        r_clr_addr  <= r_clr_addr + 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          r_state    <= ST_RUN;
          clear_busy <= 1'b0;
        end
      end else begin
        r_tag1.valid <= w_hs && !w_we;
        r_tag1.idx   <= w_sel;
        if (w_hs) begin
          sram_csb0   <= 1'b0;
          sram_web0   <= !w_we;
          sram_wmask0 <= w_wmask;
          sram_addr0  <= w_addr;
          sram_din0   <= w_wdata;
        end else begin
          sram_csb0 <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: macro model, cycle-level behavioural scoreboard and directed scenarios.
module tb_sram_rw_arbiter;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst0 = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we = '0;
  logic [15:0]   req_wmask = '0;
  logic [17:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;

  logic [1:0]    req_ready, rsp_valid;
  logic [63:0]   rsp_rdata, sram_din0, sram_dout0;
  logic          clear_busy, sram_csb0, sram_web0;
  logic [7:0]    sram_wmask0;
  logic [8:0]    sram_addr0;

  logic [1:0]    u0_req_ready, u0_rsp_valid;
  logic [63:0]   u0_rsp_rdata, u0_din0;
  logic          u0_clear_busy, u0_csb0, u0_web0;
  logic [7:0]    u0_wmask0;
  logic [8:0]    u0_addr0;
  logic [63:0]   u0_dout0 = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_rw_arbiter #(.CLEAR_ON_RESET(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_busy(clear_busy),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  sram_rw_arbiter #(.CLEAR_ON_RESET(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst0), .req_valid(req_valid), .req_ready(u0_req_ready),
    .req_we(req_we), .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(u0_rsp_valid), .rsp_rdata(u0_rsp_rdata), .clear_busy(u0_clear_busy),
    .sram_csb0(u0_csb0), .sram_web0(u0_web0), .sram_wmask0(u0_wmask0),
    .sram_addr0(u0_addr0), .sram_din0(u0_din0), .sram_dout0(u0_dout0)
  );

  // Macro model: samples the command at posedge, writes/reads at the following negedge,
  // and drives garbage shortly after each posedge once hold time has passed.
  logic [63:0] mem [512];
  logic        m_act, m_we;
  logic [8:0]  m_addr;
  logic [7:0]  m_mask;
  logic [63:0] m_din;

  initial begin
    sram_dout0 = '0;
    m_act = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
  end

  always @(posedge clk) begin
    m_act  <= !sram_csb0;
    m_we   <= !sram_web0;
    m_addr <= sram_addr0;
    m_mask <= sram_wmask0;
    m_din  <= sram_din0;
  end

  always @(posedge clk) begin
    #1 sram_dout0 = {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (m_act) begin
      if (m_we) begin
        for (int b = 0; b < 8; b++)
          if (m_mask[b]) mem[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
      end else begin
        sram_dout0 = mem[m_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Behavioural model: word array, pending-response queue, last-grant and clear countdown.
  typedef struct {
    int          idx;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mmem [512];
  int          last_g = 1;
  int          clear_left = 0;
  bit          started = 0;
  bit          rst_prev = 0;
  logic        exp_csb = 1'b1;

  initial begin
    logic [1:0] er, ev;
    int         g;
    logic [8:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      er = 2'b00;
      if (started && clear_left == 0) begin
        if (req_valid == 2'b01) er = 2'b01;
        else if (req_valid == 2'b10) er = 2'b10;
        else if (req_valid == 2'b11) er = (last_g == 1) ? 2'b01 : 2'b10;
      end
      if (started) begin
        chk("req_ready", req_ready, er);
        chk("clear_busy", clear_busy, clear_left > 0);
        chk("sram_csb0", sram_csb0, exp_csb);
        ev = 2'b00;
        if (q.size() > 0 && q[0].due == cyc) ev = (q[0].idx == 1) ? 2'b10 : 2'b01;
        chk("rsp_valid", rsp_valid, ev);
        if (ev != 2'b00) begin
          chk("rsp_rdata", rsp_rdata, q[0].data);
          void'(q.pop_front());
        end
        if (rst_prev) chk("reset_rsp_rdata", rsp_rdata, 64'h0);
      end
      if (rst) begin
        started    = 1;
        rst_prev   = 1;
        q.delete();
        last_g     = 1;
        clear_left = 512;
        exp_csb    = 1'b1;
        for (int i = 0; i < 512; i++) mmem[i] = '0;
      end else if (started) begin
        rst_prev = 0;
        if (clear_left > 0) begin
          clear_left--;
          exp_csb = 1'b0;
        end else if (er != 2'b00) begin
          g       = er[1] ? 1 : 0;
          last_g  = g;
          exp_csb = 1'b0;
          a       = req_addr[g*9 +: 9];
          if (req_we[g]) begin
            for (int b = 0; b < 8; b++)
              if (req_wmask[g*8 + b]) mmem[a][b*8 +: 8] = req_wdata[g*64 + b*8 +: 8];
          end else begin
            q.push_back('{g, mmem[a], cyc + 3});
          end
        end else begin
          exp_csb = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input int i, input bit we, input logic [8:0] a, input logic [63:0] d,
                        input logic [7:0] m, output int acc);
    req_we[i]            = we;
    req_addr[i*9 +: 9]   = a;
    req_wdata[i*64 +: 64] = d;
    req_wmask[i*8 +: 8]  = m;
    req_valid[i]         = 1'b1;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (req_ready[i]) begin
        acc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    if (acc < 0) fail("accept");
  endtask

  task automatic wait_rsp(input int i, output logic [63:0] d, output int rc);
    rc = -1;
    d  = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (rsp_valid[i]) begin
        d  = rsp_rdata;
        rc = cyc;
        break;
      end
    end
    if (rc < 0) fail("response");
    @(posedge clk); #1;
  endtask

  task automatic rd(input int i, input logic [8:0] a, output logic [63:0] d);
    int acc, rc;
    do_req(i, 1'b0, a, 64'h0, 8'h00, acc);
    wait_rsp(i, d, rc);
  endtask

  task automatic wait_clear();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (!clear_busy) break;
    end
    if (k == 600) fail("clear_done");
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    int          acc, rc, cnt;
    logic [1:0]  grants [8];
    int          n0, n1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    chk("reset_wmask", sram_wmask0, 8'h00);
    chk("reset_addr", sram_addr0, 9'h0);
    chk("reset_din", sram_din0, 64'h0);
    chk("reset_web", sram_web0, 1'b1);
    chk("reset_busy", clear_busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    cnt = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (!clear_busy) break;
      cnt++;
    end
    chk("clear_length", cnt, 512);
    @(posedge clk); #1;

    rd(0, 9'd0, d);   chk("clear_addr0", d, 64'h0);
    rd(1, 9'd255, d); chk("clear_addr255", d, 64'h0);
    rd(0, 9'd511, d); chk("clear_addr511", d, 64'h0);

    do_req(0, 1'b1, 9'h1A3, 64'hDEADBEEF_CAFEF00D, 8'hFF, acc);
    do_req(0, 1'b0, 9'h1A3, 64'h0, 8'h00, acc);
    wait_rsp(0, d, rc);
    chk("wr_rd_data", d, 64'hDEADBEEF_CAFEF00D);
    chk("read_latency_edges", rc - (acc + 1), 2);

    do_req(1, 1'b1, 9'h040, 64'h11111111_11111111, 8'hFF, acc);
    do_req(1, 1'b1, 9'h040, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, acc);
    rd(1, 9'h040, d);
    chk("byte_mask", d, 64'h11111111_FFFFFFFF);

    for (int k = 0; k < 4; k++)
      do_req(0, 1'b1, 9'h080 + 9'(k), 64'hA000_0000_0000_0000 + 64'(k), 8'hFF, acc);
    for (int k = 0; k < 4; k++)
      do_req(1, 1'b1, 9'h090 + 9'(k), 64'hB000_0000_0000_0000 + 64'(k), 8'hFF, acc);

    n0 = 0; n1 = 0;
    req_we = 2'b00;
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      req_addr[8:0]  = 9'h080 + 9'(n0);
      req_addr[17:9] = 9'h090 + 9'(n1);
      @(negedge clk); #1;
      grants[c] = req_ready;
      @(posedge clk); #1;
      if (grants[c] == 2'b01) n0++;
      else if (grants[c] == 2'b10) n1++;
    end
    req_valid = 2'b00;
    for (int c = 0; c < 8; c++)
      chk($sformatf("grant_%0d", c), grants[c], (c % 2 == 0) ? 2'b01 : 2'b10);
    repeat (5) @(posedge clk);
    #1;

    do_req(0, 1'b1, 9'd5, 64'hA5A5_0000_5A5A_1234, 8'hFF, acc);
    do_req(0, 1'b0, 9'd5, 64'h0, 8'h00, acc);
    wait_rsp(0, d, rc);
    chk("back_to_back_raw", d, 64'hA5A5_0000_5A5A_1234);

    do_req(0, 1'b0, 9'd5, 64'h0, 8'h00, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midreset_csb", sram_csb0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("midreset_no_rsp", rsp_valid, 2'b00);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    wait_clear();
    rd(0, 9'd5, d);
    chk("after_reclear", d, 64'h0);

    req_we[0] = 1'b0;
    req_addr[8:0] = 9'd7;
    req_valid = 2'b01;
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk); #1;
    chk("noclear_ready", u0_req_ready, 2'b01);
    chk("noclear_busy", u0_clear_busy, 1'b0);
    chk("noclear_csb_reset", u0_csb0, 1'b1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("noclear_csb_issue", u0_csb0, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
